// File: rtl/control_unit_pipe.sv
// control_unit_pipe
//   Pipelined control unit for an ARM-subset core. Decodes Instr[31:12] in D,
//   carries the control word through D->E->M->W registers and evaluates the
//   condition field in E against a stored NZCV flags register. Condition
//   failure suppresses every architectural side effect of the instruction.
//
// Ports
//   CLK, Reset       clock (rising edge) and asynchronous active-low reset
//   InstrD[19:0]     Instr[31:12] of the instruction in decode
//   ALUFlagsE[3:0]   NZCV produced by the ALU for the instruction in E
//   FlushE           replace the instruction entering E by a bubble
//   RegSrcD, ImmSrcD decode-stage register-read / immediate-extend selects
//   ALUSrcE, ALUControlE, MemtoRegE, CondExE, BranchTakenE   execute stage
//   MemWriteM, RegWriteM                                     memory stage
//   MemtoRegW, RegWriteW, PCSrcW                             writeback stage
//   PCWrPendingF     an R15 write is in flight in D, E or M
//   SquashCnt        count of condition-failed instructions (option only)
//
// Build option
//   CU_SQUASH_CNT_EN : adds the saturating SquashCnt counter and its port.
module control_unit_pipe #(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [19:0]          InstrD,
    input  logic [3:0]           ALUFlagsE,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchTakenE,
    output logic                 MemtoRegE,
    output logic                 CondExE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 MemtoRegW,
    output logic                 RegWriteW,
    output logic                 PCSrcW,
    output logic                 PCWrPendingF
`ifdef CU_SQUASH_CNT_EN
    ,
    output logic [CNT_W-1:0]     SquashCnt
`endif
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    // Instruction fields (InstrD bit k holds Instr[k+12])
    logic [3:0] cond_d;
    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] rd_d;
    assign cond_d  = InstrD[19:16];
    assign op_d    = InstrD[15:14];
    assign funct_d = InstrD[13:8];
    assign rd_d    = InstrD[3:0];

    // Rn is only consumed by the datapath.
    logic unused_bits;
    assign unused_bits = ^{InstrD[7:4], CNT_W[0]};

    // ---------------- Decode (combinational, D) ----------------
    logic       regw_d, memw_d, memtoreg_d, branch_d, alusrc_d, pcs_d;
    logic [1:0] flagw_d, regsrc_d, immsrc_d;
    logic [2:0] alu_d;
    logic       dp_known, dp_cmp;

    always_comb begin
        regw_d     = 1'b0;
        memw_d     = 1'b0;
        memtoreg_d = 1'b0;
        branch_d   = 1'b0;
        alusrc_d   = 1'b0;
        flagw_d    = 2'b00;
        regsrc_d   = 2'b00;
        immsrc_d   = 2'b00;
        alu_d      = ALU_ADD;
        dp_known   = 1'b1;
        dp_cmp     = 1'b0;
        case (op_d)
            2'b00: begin
                case (funct_d[4:1])
                    4'b0100: alu_d = ALU_ADD;
                    4'b0010: alu_d = ALU_SUB;
                    4'b0000: alu_d = ALU_AND;
                    4'b1100: alu_d = ALU_ORR;
                    4'b0001: alu_d = ALU_EOR;
                    4'b1101: alu_d = ALU_MOV;
                    4'b1010: begin
                        alu_d  = ALU_SUB;
                        dp_cmp = 1'b1;
                    end
                    default: dp_known = 1'b0;
                endcase
                if (dp_known) begin
                    alusrc_d   = funct_d[5];
                    regw_d     = ~dp_cmp;
                    flagw_d[1] = funct_d[0];
                    // Only arithmetic ops define C and V.
                    flagw_d[0] = funct_d[0] & ((alu_d == ALU_ADD) | (alu_d == ALU_SUB));
                end else begin
                    alu_d = ALU_ADD;
                end
            end
            2'b01: begin
                alusrc_d = 1'b1;
                immsrc_d = 2'b01;
                if (funct_d[0]) begin
                    regw_d     = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    memw_d      = 1'b1;
                    regsrc_d[1] = 1'b1;
                end
            end
            2'b10: begin
                alusrc_d    = 1'b1;
                immsrc_d    = 2'b10;
                regsrc_d[0] = 1'b1;
                branch_d    = 1'b1;
            end
            default: ;
        endcase
        pcs_d = regw_d & (rd_d == 4'hF);
    end

    assign RegSrcD = regsrc_d;
    assign ImmSrcD = immsrc_d;

    // ---------------- D -> E register ----------------
    // valid_e_reg distinguishes a real instruction from a reset/flush bubble.
    logic       valid_e_reg, regw_e_reg, memw_e_reg, memtoreg_e_reg;
    logic       branch_e_reg, alusrc_e_reg, pcs_e_reg;
    logic [1:0] flagw_e_reg;
    logic [2:0] alu_e_reg;
    logic [3:0] cond_e_reg;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset || FlushE) begin
            if (!Reset || FlushE) begin
                valid_e_reg    <= 1'b0;
                regw_e_reg     <= 1'b0;
                memw_e_reg     <= 1'b0;
                memtoreg_e_reg <= 1'b0;
                branch_e_reg   <= 1'b0;
                alusrc_e_reg   <= 1'b0;
                pcs_e_reg      <= 1'b0;
                flagw_e_reg    <= 2'b00;
                alu_e_reg      <= 3'd0;
                cond_e_reg     <= 4'd0;
            end
        end else begin
            valid_e_reg    <= 1'b1;
            regw_e_reg     <= regw_d;
            memw_e_reg     <= memw_d;
            memtoreg_e_reg <= memtoreg_d;
            branch_e_reg   <= branch_d;
            alusrc_e_reg   <= alusrc_d;
            pcs_e_reg      <= pcs_d;
            flagw_e_reg    <= flagw_d;
            alu_e_reg      <= alu_d;
            cond_e_reg     <= cond_d;
        end
    end

    // ---------------- Condition check (E) ----------------
    logic [3:0] flags_reg;   // {N, Z, C, V}
    logic       flag_n, flag_z, flag_c, flag_v, cond_pass, condex_e;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e_reg)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign condex_e = valid_e_reg & cond_pass;

    // Flags update at the end of E; the check above only sees older writers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            flags_reg <= 4'd0;
        end else begin
            if (flagw_e_reg[1] && condex_e) flags_reg[3:2] <= ALUFlagsE[3:2];
            if (flagw_e_reg[0] && condex_e) flags_reg[1:0] <= ALUFlagsE[1:0];
        end
    end

    // ---------------- E -> M -> W registers ----------------
    logic regw_m_reg, memw_m_reg, memtoreg_m_reg, pcs_m_reg;
    logic regw_w_reg, memtoreg_w_reg, pcs_w_reg;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            regw_m_reg     <= 1'b0;
            memw_m_reg     <= 1'b0;
            memtoreg_m_reg <= 1'b0;
            pcs_m_reg      <= 1'b0;
            regw_w_reg     <= 1'b0;
            memtoreg_w_reg <= 1'b0;
            pcs_w_reg      <= 1'b0;
        end else begin
            regw_m_reg     <= regw_e_reg & condex_e;
            memw_m_reg     <= memw_e_reg & condex_e;
            memtoreg_m_reg <= memtoreg_e_reg;
            pcs_m_reg      <= pcs_e_reg & condex_e;
            regw_w_reg     <= regw_m_reg;
            memtoreg_w_reg <= memtoreg_m_reg;
            pcs_w_reg      <= pcs_m_reg;
        end
    end

`ifdef CU_SQUASH_CNT_EN
    logic [CNT_W-1:0] squash_cnt_reg;
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            squash_cnt_reg <= '0;
        end else if (valid_e_reg && !cond_pass && (squash_cnt_reg != '1)) begin
            squash_cnt_reg <= squash_cnt_reg + 1'b1;
        end
    end
    assign SquashCnt = squash_cnt_reg;
`endif

    assign ALUSrcE      = alusrc_e_reg;
    assign ALUControlE  = ALUCTRL_W'(alu_e_reg);
    assign MemtoRegE    = memtoreg_e_reg;
    assign CondExE      = condex_e;
    assign BranchTakenE = branch_e_reg & condex_e;
    assign MemWriteM    = memw_m_reg;
    assign RegWriteM    = regw_m_reg;
    assign MemtoRegW    = memtoreg_w_reg;
    assign RegWriteW    = regw_w_reg;
    assign PCSrcW       = pcs_w_reg;
    // The E term is deliberately not gated: the condition is not yet resolved
    // early enough for the fetch stall.
    assign PCWrPendingF = pcs_d | pcs_e_reg | pcs_m_reg;

endmodule

// File: tb/tb_control_unit_pipe.sv
module tb_control_unit_pipe;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [19:0] InstrD = 20'd0;
    logic [3:0]  ALUFlagsE = 4'd0;
    logic        FlushE = 1'b0;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        ALUSrcE, BranchTakenE, MemtoRegE, CondExE;
    logic [2:0]  ALUControlE;
    logic        MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;
`ifdef CU_SQUASH_CNT_EN
    logic [15:0] SquashCnt;
`endif

    control_unit_pipe dut (
        .CLK(CLK), .Reset(Reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
        .FlushE(FlushE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .CondExE(CondExE),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .MemtoRegW(MemtoRegW),
        .RegWriteW(RegWriteW), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
`ifdef CU_SQUASH_CNT_EN
        , .SquashCnt(SquashCnt)
`endif
    );

    always #5 CLK = ~CLK;

    localparam logic [19:0] I_ADD   = 20'hE2821;  // ADD R1,R2,#5
    localparam logic [19:0] I_STR   = 20'hE5801;  // STR R1,[R0]
    localparam logic [19:0] I_LDRPC = 20'hE59FF;  // LDR PC,[PC]
    localparam logic [19:0] I_SUBS  = 20'hE2500;  // SUBS R0,R0,#1
    localparam logic [19:0] I_BEQ   = 20'h0A000;
    localparam logic [19:0] I_BNE   = 20'h1A000;
    localparam logic [19:0] I_NOP   = 20'hEC000;  // Op=11: no control

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        bit       valid, regw, memw, memtoreg, branch, alusrc, pcs;
        bit [1:0] flagw, regsrc, immsrc;
        bit [2:0] alu;
        bit [3:0] cond;
    } ctl_t;

    int dp_alu[16];        // DP cmd -> ALU code, -1 = not supported
    ctl_t me;              // instruction in E
    bit   mm_regw, mm_memw, mm_memtoreg, mm_pcs;
    bit   mw_regw, mw_memtoreg, mw_pcs;
    bit [3:0] mflags;
    int unsigned msq;

    function automatic ctl_t tb_decode(input logic [19:0] i);
        ctl_t r = '{default: 0};
        bit [1:0] op = i[15:14];
        bit [5:0] f  = i[13:8];
        r.cond = i[19:16];
        if (op == 2'b00) begin
            if (dp_alu[f[4:1]] >= 0) begin
                r.alu      = 3'(dp_alu[f[4:1]]);
                r.alusrc   = f[5];
                r.regw     = (f[4:1] != 4'b1010);
                r.flagw[1] = f[0];
                r.flagw[0] = f[0] && (f[4:1] inside {4'b0100, 4'b0010, 4'b1010});
            end
        end else if (op == 2'b01) begin
            r.alusrc = 1; r.immsrc = 2'b01;
            if (f[0]) begin r.regw = 1; r.memtoreg = 1; end
            else begin r.memw = 1; r.regsrc = 2'b10; end
        end else if (op == 2'b10) begin
            r.alusrc = 1; r.immsrc = 2'b10; r.regsrc = 2'b01; r.branch = 1;
        end
        r.pcs = r.regw && (i[3:0] == 4'hF);
        return r;
    endfunction

    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] fl);
        bit n = fl[3], z = fl[2], cy = fl[1], v = fl[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        me = '{default: 0};
        {mm_regw, mm_memw, mm_memtoreg, mm_pcs} = 4'b0;
        {mw_regw, mw_memtoreg, mw_pcs} = 3'b0;
        mflags = 4'd0;
        msq = 0;
    endtask

    task automatic model_advance(input logic [19:0] instr, input logic flush, input logic [3:0] fl);
        bit pass = cond_ok(me.cond, mflags);
        bit cx = me.valid && pass;
        if (me.valid && !pass && msq != 32'hFFFF) msq++;
        if (me.flagw[1] && cx) mflags[3:2] = fl[3:2];
        if (me.flagw[0] && cx) mflags[1:0] = fl[1:0];
        mw_regw = mm_regw; mw_memtoreg = mm_memtoreg; mw_pcs = mm_pcs;
        mm_regw = me.regw && cx; mm_memw = me.memw && cx;
        mm_memtoreg = me.memtoreg; mm_pcs = me.pcs && cx;
        if (flush) me = '{default: 0};
        else begin me = tb_decode(instr); me.valid = 1; end
    endtask

    // Apply one cycle of stimulus, compare every output, then clock the model.
    task automatic step(input logic [19:0] instr, input logic flush,
                        input logic [3:0] fl, input logic rst_n_in);
        ctl_t d;
        bit cx;
        InstrD = instr; FlushE = flush; ALUFlagsE = fl; Reset = rst_n_in;
        if (!rst_n_in) model_clear();
        #1;
        d  = tb_decode(instr);
        cx = me.valid && cond_ok(me.cond, mflags);
        check("RegSrcD", 32'(RegSrcD), 32'(d.regsrc));
        check("ImmSrcD", 32'(ImmSrcD), 32'(d.immsrc));
        check("ALUSrcE", 32'(ALUSrcE), 32'(me.alusrc));
        check("ALUControlE", 32'(ALUControlE), 32'(me.alu));
        check("MemtoRegE", 32'(MemtoRegE), 32'(me.memtoreg));
        check("CondExE", 32'(CondExE), 32'(cx));
        check("BranchTakenE", 32'(BranchTakenE), 32'(me.branch && cx));
        check("MemWriteM", 32'(MemWriteM), 32'(mm_memw));
        check("RegWriteM", 32'(RegWriteM), 32'(mm_regw));
        check("MemtoRegW", 32'(MemtoRegW), 32'(mw_memtoreg));
        check("RegWriteW", 32'(RegWriteW), 32'(mw_regw));
        check("PCSrcW", 32'(PCSrcW), 32'(mw_pcs));
        check("PCWrPendingF", 32'(PCWrPendingF), 32'(d.pcs || me.pcs || mm_pcs));
`ifdef CU_SQUASH_CNT_EN
        check("SquashCnt", 32'(SquashCnt), msq);
`endif
        @(posedge CLK);
        if (rst_n_in) model_advance(instr, flush, fl);
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [19:0] rand_instr();
        logic [19:0] i = 20'($urandom);
        logic [3:0] cmds [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                                 4'b0001, 4'b1101, 4'b1010, 4'b1000};
        int k = $urandom_range(0, 9);
        if (k < 5) begin
            i[15:14] = 2'b00;
            i[12:9]  = cmds[$urandom_range(0, 7)];
        end else if (k < 7) i[15:14] = 2'b01;
        else if (k < 9)     i[15:14] = 2'b10;
        else                i[15:14] = 2'b11;
        if ($urandom_range(0, 3) == 0) i[3:0] = 4'hF;
        if ($urandom_range(0, 2) == 0) i[19:16] = 4'hE;
        return i;
    endfunction

    // ---------------- Hand-sequence helpers ----------------
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; InstrD = I_NOP; FlushE = 1'b0; ALUFlagsE = 4'd0;
        cyc();
        Reset = 1'b1;
    endtask

    typedef struct {
        logic [19:0] instr;
        logic [1:0]  regsrc, immsrc;
        logic        alusrc;
        logic [2:0]  alu;
        logic        memtoreg, pcwr;
    } vec_t;
    vec_t tbl [14];

    initial begin
        foreach (dp_alu[k]) dp_alu[k] = -1;
        dp_alu[4'b0100] = 0; dp_alu[4'b0010] = 1; dp_alu[4'b0000] = 2;
        dp_alu[4'b1100] = 3; dp_alu[4'b0001] = 4; dp_alu[4'b1101] = 5;
        dp_alu[4'b1010] = 1;

        tbl[0]  = '{I_ADD,     2'b00, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{I_STR,     2'b10, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{I_LDRPC,   2'b00, 2'b01, 1'b1, 3'd0, 1'b1, 1'b1};
        tbl[3]  = '{20'hEA000, 2'b01, 2'b10, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{I_SUBS,    2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{20'hE1843, 2'b00, 2'b00, 1'b0, 3'd3, 1'b0, 1'b0};  // ORR
        tbl[6]  = '{20'hE0021, 2'b00, 2'b00, 1'b0, 3'd2, 1'b0, 1'b0};  // AND
        tbl[7]  = '{20'hE0221, 2'b00, 2'b00, 1'b0, 3'd4, 1'b0, 1'b0};  // EOR
        tbl[8]  = '{20'hE1A0F, 2'b00, 2'b00, 1'b0, 3'd5, 1'b0, 1'b1};  // MOV PC,LR
        tbl[9]  = '{20'hE3500, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};  // CMP
        tbl[10] = '{20'hE350F, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};  // CMP, Rd=F
        tbl[11] = '{20'hE310F, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};  // TST: NOP
        tbl[12] = '{I_NOP,     2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};  // Op=11
        tbl[13] = '{20'hE08FF, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1};  // ADD PC,PC,R0

        @(negedge CLK);
        #1;

        // Table: D outputs while held in reset, E outputs one edge after release.
        for (int n = 0; n < 14; n++) begin
            Reset = 1'b0; InstrD = tbl[n].instr; FlushE = 1'b0; ALUFlagsE = 4'd0;
            #1;
            check($sformatf("tbl%0d RegSrcD", n), 32'(RegSrcD), 32'(tbl[n].regsrc));
            check($sformatf("tbl%0d ImmSrcD", n), 32'(ImmSrcD), 32'(tbl[n].immsrc));
            check($sformatf("tbl%0d PCWrPendingF", n), 32'(PCWrPendingF), 32'(tbl[n].pcwr));
            check($sformatf("tbl%0d RegWriteW rst", n), 32'(RegWriteW), 32'd0);
            Reset = 1'b1;
            @(posedge CLK);
            #1;
            check($sformatf("tbl%0d ALUSrcE", n), 32'(ALUSrcE), 32'(tbl[n].alusrc));
            check($sformatf("tbl%0d ALUControlE", n), 32'(ALUControlE), 32'(tbl[n].alu));
            check($sformatf("tbl%0d MemtoRegE", n), 32'(MemtoRegE), 32'(tbl[n].memtoreg));
            Reset = 1'b0;
            @(negedge CLK);
            #1;
        end

        // ADD latency: RegWriteW three edges after D.
        do_reset();
        InstrD = I_ADD; #1; cyc();
        InstrD = I_NOP; #1;
        check("add ALUSrcE", 32'(ALUSrcE), 32'd1);
        check("add ALUControlE", 32'(ALUControlE), 32'd0);
        check("add RegWriteM early", 32'(RegWriteM), 32'd0);
        cyc();
        check("add RegWriteM", 32'(RegWriteM), 32'd1);
        check("add RegWriteW early", 32'(RegWriteW), 32'd0);
        cyc();
        check("add RegWriteW", 32'(RegWriteW), 32'd1);
        cyc();
        check("add RegWriteW after", 32'(RegWriteW), 32'd0);

        // SUBS sets Z, then BEQ taken and BNE not.
        do_reset();
        InstrD = I_SUBS; #1; cyc();
        InstrD = I_BEQ; ALUFlagsE = 4'b0100; #1;
        check("subs CondExE", 32'(CondExE), 32'd1);
        cyc();
        InstrD = I_BNE; ALUFlagsE = 4'b0000; #1;
        check("beq BranchTakenE", 32'(BranchTakenE), 32'd1);
        check("beq CondExE", 32'(CondExE), 32'd1);
        cyc();
        InstrD = I_NOP; #1;
        check("bne BranchTakenE", 32'(BranchTakenE), 32'd0);
        check("bne CondExE", 32'(CondExE), 32'd0);

        // Flushed SUBS: bubble in E/M/W and flags untouched.
        do_reset();
        InstrD = I_SUBS; FlushE = 1'b1; ALUFlagsE = 4'b0100; #1; cyc();
        FlushE = 1'b0; InstrD = I_BEQ; #1;
        check("flush ALUSrcE", 32'(ALUSrcE), 32'd0);
        check("flush ALUControlE", 32'(ALUControlE), 32'd0);
        check("flush CondExE", 32'(CondExE), 32'd0);
        cyc();
        InstrD = I_NOP; ALUFlagsE = 4'd0; #1;
        check("flush RegWriteM", 32'(RegWriteM), 32'd0);
        check("flush flags CondExE", 32'(CondExE), 32'd0);
        check("flush BranchTakenE", 32'(BranchTakenE), 32'd0);
        cyc();
        check("flush RegWriteW", 32'(RegWriteW), 32'd0);

        // LDR into PC: pending for D, E, M; PCSrcW in W.
        do_reset();
        InstrD = I_LDRPC; #1;
        check("ldrpc pend D", 32'(PCWrPendingF), 32'd1);
        check("ldrpc PCSrcW early", 32'(PCSrcW), 32'd0);
        cyc();
        InstrD = I_NOP; #1;
        check("ldrpc pend E", 32'(PCWrPendingF), 32'd1);
        check("ldrpc MemtoRegE", 32'(MemtoRegE), 32'd1);
        cyc();
        check("ldrpc pend M", 32'(PCWrPendingF), 32'd1);
        cyc();
        check("ldrpc pend W", 32'(PCWrPendingF), 32'd0);
        check("ldrpc PCSrcW", 32'(PCSrcW), 32'd1);
        check("ldrpc MemtoRegW", 32'(MemtoRegW), 32'd1);

        // Asynchronous reset with a full pipeline, then restart.
        do_reset();
        InstrD = I_ADD; #1; cyc();
        InstrD = I_STR; #1; cyc();
        InstrD = I_LDRPC; #1; cyc();
        check("pre-rst MemWriteM", 32'(MemWriteM), 32'd1);
        check("pre-rst RegWriteW", 32'(RegWriteW), 32'd1);
        Reset = 1'b0; #1;
        check("rst ALUSrcE", 32'(ALUSrcE), 32'd0);
        check("rst MemtoRegE", 32'(MemtoRegE), 32'd0);
        check("rst CondExE", 32'(CondExE), 32'd0);
        check("rst MemWriteM", 32'(MemWriteM), 32'd0);
        check("rst RegWriteM", 32'(RegWriteM), 32'd0);
        check("rst RegWriteW", 32'(RegWriteW), 32'd0);
        check("rst MemtoRegW", 32'(MemtoRegW), 32'd0);
        check("rst PCSrcW", 32'(PCSrcW), 32'd0);
        check("rst PCWrPendingF (D only)", 32'(PCWrPendingF), 32'd1);
        check("rst ImmSrcD", 32'(ImmSrcD), 32'b01);
        InstrD = I_ADD; Reset = 1'b1;
        cyc();
        InstrD = I_NOP; #1;
        check("restart ALUSrcE", 32'(ALUSrcE), 32'd1);
        check("restart RegWriteM", 32'(RegWriteM), 32'd0);
        cyc();
        cyc();
        check("restart RegWriteW", 32'(RegWriteW), 32'd1);

        // Randomized run against the reference model.
        step(I_NOP, 1'b0, 4'd0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            step(rand_instr(), ($urandom_range(0, 7) == 0), 4'($urandom),
                 ($urandom_range(0, 49) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
